// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter (and a future receiver):
//   - uart_state_t : framing FSM states
//   - LCR_*        : bit positions inside the line control register
//   - wordLen()    : decodes the two word-length-select bits to a bit count
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Line control register bit positions (LCR_WLS is the LSB of a 2-bit field)
  localparam int LCR_WLS   = 0;
  localparam int LCR_STB   = 2;
  localparam int LCR_PEN   = 3;
  localparam int LCR_EPS   = 4;
  localparam int LCR_STICK = 5;
  localparam int LCR_BRK   = 6;

  // 00 -> 5 bits ... 11 -> 8 bits
  function automatic logic [3:0] wordLen(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period timer. A reload starts a new bit period of max(divisor,1)
// clock cycles; o_bitEnd is high during the last cycle of that period.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_reload   restart the period using i_divisor
//   i_divisor  clock cycles per bit (0 behaves as 1)
//   o_bitEnd   one-cycle tick marking the final cycle of the bit
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_reload,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_bitEnd
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_reloadVal;

  // A zero divisor would never tick, so it is promoted to one cycle per bit.
  // The counter holds the number of cycles left in the current bit, so the
  // final cycle is the one where it reads 1.
  always_comb begin
    w_reloadVal = (i_divisor == '0) ? DIV_W'(1) : i_divisor;
    o_bitEnd    = (r_cnt == DIV_W'(1));
  end

  // Down-counter: reload wins over counting, and it parks at zero once a
  // period expires without a reload (e.g. after the last stop bit).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= w_reloadVal;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 16550-style serial transmitter: start bit, 5..8 data bits LSB first,
// optional parity (odd/even/stick), 1 or 2 stop bits, live break control.
// Ports:
//   pclk       clock, rising edge
//   preset_n   synchronous active-low reset
//   start_i    transmit request, honoured only while idle
//   data_i     character to send
//   lcr_i      line control: [1:0] wls, [2] stb, [3] pen, [4] eps,
//              [5] stick, [6] break (bit 7 unused)
//   divisor_i  pclk cycles per bit (0 behaves as 1)
//   txd_o      registered serial output, idle high
//   busy_o     high whenever a character is in flight
//   done_o     one-cycle pulse in the final stop-bit cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             start_i,
  input  logic [7:0]       data_i,
  input  logic [7:0]       lcr_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             txd_o,
  output logic             busy_o,
  output logic             done_o
);

  uart_state_t      r_state;
  uart_state_t      w_stateNext;
  logic [7:0]       r_data;
  logic [5:0]       r_lcr;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bitIdx;
  logic [2:0]       w_bitIdxNext;
  logic             r_stop2;
  logic             w_stop2Next;
  logic             r_txd;
  logic             w_txdNext;

  logic             w_accept;
  logic             w_reload;
  logic             w_bitEnd;
  logic [DIV_W-1:0] w_div;
  logic [3:0]       w_wordLen;
  logic             w_lastBit;
  logic [7:0]       w_dataMask;
  logic             w_dataXor;
  logic             w_parity;
  logic             w_unused;

  // LCR bit 7 has no meaning for the transmitter.
  assign w_unused = lcr_i[7];

  // Frame configuration decode. The divisor used for the very first bit
  // comes straight from the input because the latch happens on the same edge.
  // Parity covers only the bits actually sent, hence the word-length mask.
  always_comb begin
    w_accept   = (r_state == IDLE) && start_i;
    w_div      = (r_state == IDLE) ? divisor_i : r_div;
    w_wordLen  = wordLen(r_lcr[LCR_WLS +: 2]);
    w_lastBit  = ({1'b0, r_bitIdx} == (w_wordLen - 4'd1));
    w_dataMask = 8'hFF >> (4'd8 - w_wordLen);
    w_dataXor  = ^(r_data & w_dataMask);
    if (r_lcr[LCR_STICK]) begin
      w_parity = ~r_lcr[LCR_EPS];
    end else if (r_lcr[LCR_EPS]) begin
      w_parity = w_dataXor;
    end else begin
      w_parity = ~w_dataXor;
    end
  end

  // The bit timer restarts at acceptance and at every bit boundary that
  // leads into another bit; it is left to expire after the last stop bit.
  assign w_reload = w_accept || (w_bitEnd && (w_stateNext != IDLE));

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .i_clk     (pclk),
    .i_rst_n   (preset_n),
    .i_reload  (w_reload),
    .i_divisor (w_div),
    .o_bitEnd  (w_bitEnd)
  );

  // State register plus the configuration latch and the registered line.
  // txd is loaded from the value the next state will present, so the line
  // changes on the same edge as the state. Break is applied here from the
  // live input and never touches the FSM.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_lcr    <= '0;
      r_div    <= '0;
      r_bitIdx <= '0;
      r_stop2  <= 1'b0;
      r_txd    <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_bitIdx <= w_bitIdxNext;
      r_stop2  <= w_stop2Next;
      r_txd    <= lcr_i[LCR_BRK] ? 1'b0 : w_txdNext;
      if (w_accept) begin
        r_data <= data_i;
        r_lcr  <= lcr_i[5:0];
        r_div  <= divisor_i;
      end
    end
  end

  // Next-state logic. Every transition out of a bit happens on the bit-end
  // tick. r_stop2 remembers that the first of two stop bits has been sent.
  always_comb begin
    w_stateNext  = r_state;
    w_bitIdxNext = r_bitIdx;
    w_stop2Next  = r_stop2;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_stateNext = START;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext  = DATA;
          w_bitIdxNext = 3'd0;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          if (w_lastBit) begin
            w_stateNext = r_lcr[LCR_PEN] ? PARITY : STOP;
            w_stop2Next = 1'b0;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = STOP;
          w_stop2Next = 1'b0;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          if (!r_lcr[LCR_STB] || r_stop2) begin
            w_stateNext = IDLE;
          end else begin
            w_stop2Next = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Outputs. w_txdNext is the line level belonging to the upcoming state;
  // DATA is only ever entered from START or DATA, so the latched character
  // is always valid when it is indexed.
  always_comb begin
    busy_o = (r_state != IDLE);
    done_o = (r_state == STOP) && w_bitEnd && (!r_lcr[LCR_STB] || r_stop2);
    case (w_stateNext)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = r_data[w_bitIdxNext];
      PARITY:  w_txdNext = w_parity;
      default: w_txdNext = 1'b1;
    endcase
  end

  assign txd_o = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Scoreboard bench for uart_tx. Each accepted request pushes the expected
// frame (bit list + cycles per bit) built from the line rules; a monitor
// on the falling edge follows busy_o, compares txd_o and done_o cycle by
// cycle against the head of the queue, and retires it at the last cycle.
module tb_uart_tx;

  localparam int DIV_W = 16;

  logic             pclk = 1'b0;
  logic             preset_n;
  logic             start_i;
  logic [7:0]       data_i;
  logic [7:0]       lcr_i;
  logic [DIV_W-1:0] divisor_i;
  logic             txd_o;
  logic             busy_o;
  logic             done_o;

  typedef struct {
    logic [11:0] bits;
    int          nBits;
    int          per;
  } frame_t;

  frame_t expQ[$];
  int     nChecks = 0;
  int     nFails  = 0;

  always #5 pclk = ~pclk;

  uart_tx #(
    .DIV_W(DIV_W)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .start_i   (start_i),
    .data_i    (data_i),
    .lcr_i     (lcr_i),
    .divisor_i (divisor_i),
    .txd_o     (txd_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expired wait bounds are reported as failed checks.
  task automatic reportTimeout(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  function automatic frame_t buildFrame(input logic [7:0] data, input logic [7:0] lcr,
                                        input int div);
    frame_t f;
    int     wl;
    int     ones;
    logic   par;
    f.bits  = '1;
    wl      = 5 + int'(lcr[1:0]);
    ones    = 0;
    f.bits[0] = 1'b0;
    f.nBits = 1;
    for (int i = 0; i < wl; i++) begin
      f.bits[f.nBits] = data[i];
      f.nBits++;
      if (data[i]) ones++;
    end
    if (lcr[3]) begin
      if (lcr[5])      par = !lcr[4];
      else if (lcr[4]) par = ((ones % 2) == 1);
      else             par = ((ones % 2) == 0);
      f.bits[f.nBits] = par;
      f.nBits++;
    end
    f.bits[f.nBits] = 1'b1;
    f.nBits++;
    if (lcr[2]) begin
      f.bits[f.nBits] = 1'b1;
      f.nBits++;
    end
    f.per = (div == 0) ? 1 : div;
    return f;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    if (busy_o !== 1'b0) reportTimeout("idleWait");
  endtask

  // Issues one request and records its expected frame. Returns one step
  // after the accepting edge, i.e. in the first START cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] lcr,
                               input int div, input bit scramble);
    waitIdle();
    data_i    = data;
    lcr_i     = lcr;
    divisor_i = DIV_W'(div);
    start_i   = 1'b1;
    expQ.push_back(buildFrame(data, lcr, div));
    tick(1);
    start_i = 1'b0;
    if (scramble) begin
      data_i    = 8'($urandom);
      lcr_i     = 8'($urandom) & 8'h3F;
      divisor_i = DIV_W'($urandom);
    end
  endtask

  // Monitor: frames start when busy_o rises; break seen at the previous
  // sample forces the line low; a reset observed mid-frame aborts it.
  bit     inFrame    = 1'b0;
  bit     rogue      = 1'b0;
  bit     gapPending = 1'b0;
  logic   prevBrk    = 1'b0;
  int     cycle      = 0;
  int     total;
  logic   expTxd;
  frame_t curF;

  always @(negedge pclk) begin
    if (!inFrame) begin
      if (gapPending) begin
        checkOutput("idleGap", busy_o, 0);
        gapPending = 1'b0;
      end else if (busy_o === 1'b1 && !rogue) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedFrame: busy_o=%0b with empty queue at %0t", busy_o, $time);
          rogue = 1'b1;
        end else begin
          inFrame = 1'b1;
          cycle   = 0;
        end
      end
      if (busy_o === 1'b0) rogue = 1'b0;
      if (!inFrame && done_o !== 1'b0) checkOutput("strayDone", done_o, 0);
    end
    if (inFrame) begin
      curF  = expQ[0];
      total = curF.nBits * curF.per;
      if (busy_o !== 1'b1) begin
        checkOutput("busyInFrame", busy_o, 1);
        expQ.delete(0);
        inFrame = 1'b0;
      end else begin
        expTxd = prevBrk ? 1'b0 : curF.bits[cycle / curF.per];
        checkOutput("txd", txd_o, expTxd);
        checkOutput("done", done_o, (cycle == total - 1));
        if (cycle == total - 1) begin
          expQ.delete(0);
          inFrame    = 1'b0;
          gapPending = 1'b1;
        end else begin
          cycle++;
        end
        if (inFrame && !preset_n) begin
          expQ.delete(0);
          inFrame = 1'b0;
        end
      end
    end
    prevBrk = lcr_i[6];
  end

  initial begin
    int n;
    preset_n  = 1'b0;
    start_i   = 1'b0;
    data_i    = '0;
    lcr_i     = '0;
    divisor_i = '0;
    tick(3);
    checkOutput("resetTxd", txd_o, 1);
    checkOutput("resetBusy", busy_o, 0);
    checkOutput("resetDone", done_o, 0);
    preset_n = 1'b1;
    tick(2);
    checkOutput("idleTxd", txd_o, 1);

    $display("[TB] directed frames");
    applyStimulus(8'hA5, 8'h03, 4, 1'b0);
    applyStimulus(8'h07, 8'h0C, 2, 1'b0);
    applyStimulus(8'h07, 8'h1C, 2, 1'b0);
    applyStimulus(8'($urandom), 8'h2B, 3, 1'b0);
    applyStimulus(8'($urandom), 8'h3B, 3, 1'b0);
    applyStimulus(8'h96, 8'h07, 0, 1'b0);
    applyStimulus(8'h5A, 8'h0F, 1, 1'b1);

    $display("[TB] start pulse during DATA");
    applyStimulus(8'h3C, 8'h03, 4, 1'b0);
    tick(10);
    data_i  = 8'hFF;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    waitIdle();

    $display("[TB] start held across done");
    applyStimulus(8'h3C, 8'h03, 2, 1'b0);
    n = 0;
    while (n < 1000 && done_o !== 1'b1) begin
      @(negedge pclk);
      n++;
    end
    if (done_o !== 1'b1) reportTimeout("doneWait");
    data_i    = 8'hC3;
    lcr_i     = 8'h07;
    divisor_i = DIV_W'(1);
    start_i   = 1'b1;
    expQ.push_back(buildFrame(8'hC3, 8'h07, 1));
    @(posedge pclk);
    @(posedge pclk);
    #1;
    start_i = 1'b0;
    waitIdle();

    $display("[TB] break mid-frame");
    applyStimulus(8'h55, 8'h03, 4, 1'b0);
    tick(10);
    lcr_i = lcr_i | 8'h40;
    tick(6);
    lcr_i = lcr_i & 8'hBF;
    waitIdle();

    $display("[TB] reset during DATA bit 3");
    applyStimulus(8'hA5, 8'h03, 4, 1'b0);
    tick(17);
    preset_n = 1'b0;
    tick(1);
    checkOutput("abortTxd", txd_o, 1);
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortDone", done_o, 0);
    preset_n = 1'b1;
    tick(3);

    $display("[TB] random frames");
    for (int k = 0; k < 25; k++) begin
      applyStimulus(8'($urandom), 8'($urandom) & 8'h3F, int'($urandom_range(0, 5)), 1'b1);
    end

    n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      tick(1);
      n++;
    end
    if (expQ.size() != 0) reportTimeout("scoreboardDrain");
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
